// File: rtl/aes_round_core_if.sv
// aes_round_core_if: request/response bundle for the iterative AES-128 core.
// The master side issues start/mode/data/keys and observes the result and status.
interface aes_round_core_if;
  logic          start;
  logic          mode;
  logic [127:0]  data_in;
  logic [1407:0] round_keys;
  logic [127:0]  data_out;
  logic          done;
  logic          busy;
  logic [11:0]   bcd_out;

  modport master (
    output start, mode, data_in, round_keys,
    input  data_out, done, busy, bcd_out
  );

  modport slave (
    input  start, mode, data_in, round_keys,
    output data_out, done, busy, bcd_out
  );
endinterface

// File: rtl/aes_round_core.sv
// aes_round_core: iterative AES-128 encrypt/decrypt engine, one round per clock.
// The initial AddRoundKey happens on the accepting edge, the ten rounds follow on
// the next ten edges, and only the final round result is written to data_out.
// Optional feature macro: AES_BCD_EN builds the double-dabble rendering of
// data_out[7:0] on bcd_out; without it bcd_out is tied to 12'h000.
module aes_round_core #(
  parameter int NR = 10,
  parameter int NK = 4
) (
  input logic             clk,
  input logic             rst_n,
  aes_round_core_if.slave bus
);

  localparam int BLK_W = 32 * NK;
  localparam int RK_W  = BLK_W * (NR + 1);

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t         fsm;
  fsm_t         fsm_next;
  logic [3:0]   round;
  logic         dec;
  logic [127:0] state;
  logic [127:0] data_out_r;
  logic         done_r;

  logic         accept;
  logic         finish;
  logic         last_round;
  logic [3:0]   key_idx;
  logic [127:0] rk;
  logic [127:0] init_key;
  logic [127:0] enc_next;
  logic [127:0] dec_tmp;
  logic [127:0] dec_next;
  logic [127:0] round_out;

  // GF(2^8) multiply by x modulo x^8+x^4+x^3+x+1 (0x11B).
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] acc;
    p   = a;
    acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return ginv(b);
  endfunction

  // Byte n of the state sits at [127-8n -: 8]; n = row + 4*column.
  function automatic logic [127:0] sub_bytes(input logic [127:0] blk, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) begin
      o[127-8*n -: 8] = inv ? inv_sbox(blk[127-8*n -: 8]) : sbox(blk[127-8*n -: 8]);
    end
    return o;
  endfunction

  // Row r rotates left by r (encrypt) or right by r (decrypt).
  function automatic logic [127:0] shift_rows(input logic [127:0] blk, input logic inv);
    logic [127:0] o;
    int           src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
        o[127-8*(r+4*c) -: 8] = blk[127-8*(r+4*src) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] blk);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = blk[127-8*(k+4*c) -: 8];
      o[127-8*(0+4*c) -: 8] = xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3];
      o[127-8*(1+4*c) -: 8] = a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3];
      o[127-8*(2+4*c) -: 8] = a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3];
      o[127-8*(3+4*c) -: 8] = xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] blk);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = blk[127-8*(k+4*c) -: 8];
      o[127-8*(0+4*c) -: 8] = gmul(a[0], 8'h0e) ^ gmul(a[1], 8'h0b)
                            ^ gmul(a[2], 8'h0d) ^ gmul(a[3], 8'h09);
      o[127-8*(1+4*c) -: 8] = gmul(a[0], 8'h09) ^ gmul(a[1], 8'h0e)
                            ^ gmul(a[2], 8'h0b) ^ gmul(a[3], 8'h0d);
      o[127-8*(2+4*c) -: 8] = gmul(a[0], 8'h0d) ^ gmul(a[1], 8'h09)
                            ^ gmul(a[2], 8'h0e) ^ gmul(a[3], 8'h0b);
      o[127-8*(3+4*c) -: 8] = gmul(a[0], 8'h0b) ^ gmul(a[1], 8'h0d)
                            ^ gmul(a[2], 8'h09) ^ gmul(a[3], 8'h0e);
    end
    return o;
  endfunction

  // One cipher round for the current counter value, both directions; decrypt
  // walks the key schedule backwards, and the last round drops (Inv)MixColumns.
  always_comb begin
    last_round = (round == 4'(NR));
    key_idx    = dec ? (4'(NR) - round) : round;
    rk         = bus.round_keys[RK_W-1 - BLK_W*int'(key_idx) -: BLK_W];
    init_key   = bus.mode ? bus.round_keys[BLK_W-1:0] : bus.round_keys[RK_W-1 -: BLK_W];

    enc_next = shift_rows(sub_bytes(state, 1'b0), 1'b0);
    if (!last_round) enc_next = mix_columns(enc_next);
    enc_next = enc_next ^ rk;

    dec_tmp  = sub_bytes(shift_rows(state, 1'b1), 1'b1) ^ rk;
    dec_next = last_round ? dec_tmp : inv_mix_columns(dec_tmp);

    round_out = dec ? dec_next : enc_next;
  end

  // Sequencer: idle until start, run until the tenth round completes.
  always_comb begin
    fsm_next = fsm;
    accept   = 1'b0;
    finish   = 1'b0;
    case (fsm)
      IDLE: begin
        if (bus.start) begin
          accept   = 1'b1;
          fsm_next = RUN;
        end
      end
      RUN: begin
        if (last_round) begin
          finish   = 1'b1;
          fsm_next = IDLE;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsm_next;
  end

  // Round counter, direction flag, result register and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round      <= 4'd0;
      dec        <= 1'b0;
      done_r     <= 1'b0;
      data_out_r <= '0;
    end else begin
      done_r <= finish;
      if (accept) begin
        round <= 4'd1;
        dec   <= bus.mode;
      end else if (finish) begin
        round <= 4'd0;
      end else if (fsm == RUN) begin
        round <= round + 4'd1;
      end
      if (finish) data_out_r <= round_out;
    end
  end

  // Working state: initial AddRoundKey on accept, then one round per clock.
  always_ff @(posedge clk) begin
    if (accept)            state <= bus.data_in ^ init_key;
    else if (fsm == RUN)   state <= round_out;
  end

  assign bus.data_out = data_out_r;
  assign bus.done     = done_r;
  assign bus.busy     = (fsm == RUN);

`ifdef AES_BCD_EN
  // Double-dabble: add 3 to any digit >= 5 before each left shift.
  function automatic logic [11:0] bin2bcd(input logic [7:0] bin);
    logic [19:0] sh;
    sh = {12'h000, bin};
    for (int i = 0; i < 8; i++) begin
      if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
      if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
      if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
      sh = {sh[18:0], 1'b0};
    end
    return sh[19:8];
  endfunction

  assign bus.bcd_out = bin2bcd(data_out_r[7:0]);
`else
  assign bus.bcd_out = 12'h000;
`endif

endmodule

// File: tb/tb_aes_round_core.sv
// tb_aes_round_core: directed and randomized checks of aes_round_core against
// FIPS-197 vectors and a table-driven AES reference model kept in this bench.
module tb_aes_round_core;

  logic clk;
  logic rst_n;

  aes_round_core_if bus();

  aes_round_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_miss;

  // Reference tables built from the field generator 0x03.
  logic [7:0] exp_t [256];
  int         log_t [256];
  logic [7:0] sb    [256];
  logic [7:0] isb   [256];

  function automatic logic [7:0] m_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  task automatic build_tables();
    logic [7:0] x;
    logic [7:0] b;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = i;
      x = x ^ m_xt(x);
    end
    exp_t[255] = exp_t[0];
    log_t[0]   = 0;
    for (int v = 0; v < 256; v++) begin
      b = (v == 0) ? 8'h00 : exp_t[(255 - log_t[v]) % 255];
      for (int i = 0; i < 8; i++)
        s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
      sb[v]  = s;
      isb[s] = v[7:0];
    end
  endtask

  function automatic logic [127:0] m_sub(input logic [127:0] blk, input logic inv);
    logic [127:0] o;
    for (int n = 0; n < 16; n++)
      o[127-8*n -: 8] = inv ? isb[blk[127-8*n -: 8]] : sb[blk[127-8*n -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] m_shift(input logic [127:0] blk, input logic inv);
    logic [127:0] o;
    int src;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127-8*(r+4*c) -: 8] = blk[127-8*(r+4*src) -: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] m_mix(input logic [127:0] blk, input logic inv);
    logic [127:0] o;
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    if (inv) begin coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09; end
    else     begin coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01; end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ m_mul(coef[(j - r + 4) % 4], blk[127-8*(j+4*c) -: 8]);
        o[127-8*(r+4*c) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] m_rk(input logic [1407:0] rks, input int i);
    return rks[1407-128*i -: 128];
  endfunction

  function automatic logic [1407:0] m_expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
        rc = m_xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) o[1407-32*i -: 32] = w[i];
    return o;
  endfunction

  function automatic logic [127:0] m_cipher(input logic inv, input logic [127:0] blk,
                                            input logic [1407:0] rks);
    logic [127:0] s;
    if (!inv) begin
      s = blk ^ m_rk(rks, 0);
      for (int rd = 1; rd <= 10; rd++) begin
        s = m_shift(m_sub(s, 1'b0), 1'b0);
        if (rd < 10) s = m_mix(s, 1'b0);
        s = s ^ m_rk(rks, rd);
      end
    end else begin
      s = blk ^ m_rk(rks, 10);
      for (int rd = 9; rd >= 0; rd--) begin
        s = m_sub(m_shift(s, 1'b1), 1'b1) ^ m_rk(rks, rd);
        if (rd > 0) s = m_mix(s, 1'b1);
      end
    end
    return s;
  endfunction

  function automatic logic [11:0] exp_bcd(input logic [7:0] b);
`ifdef AES_BCD_EN
    int v;
    v = int'(b);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
`else
    return (b === 8'hxx) ? 12'hfff : 12'h000;
`endif
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Full operation: start pulse, bounded wait for done, latency/result/bcd checks.
  task automatic run_op(input string tag, input logic m, input logic [127:0] din,
                        input logic [127:0] expv);
    int           lat;
    logic         seen;
    logic [127:0] prev;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.mode    = m;
    bus.data_in = din;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.mode    = ~m;
    bus.data_in = ~din;
    prev = bus.data_out;
    chk({tag, ":busy_run"}, {127'd0, bus.busy}, 128'd1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) seen = 1'b1;
      else          chk({tag, ":hold"}, bus.data_out, prev);
    end
    chk({tag, ":latency"}, 128'(lat), 128'd10);
    chk({tag, ":data"},    bus.data_out, expv);
    chk({tag, ":bcd"},     {116'd0, bus.bcd_out}, {116'd0, exp_bcd(expv[7:0])});
    chk({tag, ":busy_end"}, {127'd0, bus.busy}, 128'd0);
    @(posedge clk); #1;
    chk({tag, ":done_drop"}, {127'd0, bus.done}, 128'd0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.done && lat < 30);
  endtask

  logic [1407:0] rks;
  logic [127:0]  pt_a, pt_b, ct, tgt, exp_a, exp_b;
  logic [7:0]    lows [4];
  int            lat;
  logic          any_done;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec  = 0;
    n_miss = 0;
    build_tables();
    bus.start      = 1'b0;
    bus.mode       = 1'b0;
    bus.data_in    = '0;
    bus.round_keys = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:data_out", bus.data_out, 128'd0);
    chk("rst:done", {127'd0, bus.done}, 128'd0);
    chk("rst:busy", {127'd0, bus.busy}, 128'd0);
    chk("rst:bcd",  {116'd0, bus.bcd_out}, 128'd0);
    @(negedge clk) rst_n = 1'b1;

    // FIPS-197 C.1 encrypt and decrypt.
    rks = m_expand(128'h000102030405060708090a0b0c0d0e0f);
    bus.round_keys = rks;
    run_op("c1_enc", 1'b0, 128'h00112233445566778899aabbccddeeff,
           128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    run_op("c1_dec", 1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
           128'h00112233445566778899aabbccddeeff);

    // FIPS-197 appendix B encrypt and decrypt.
    rks = m_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    bus.round_keys = rks;
    run_op("b_enc", 1'b0, 128'h3243f6a8885a308d313198a2e0370734,
           128'h3925841d02dc09fbdc118597196a0b32);
    run_op("b_dec", 1'b1, 128'h3925841d02dc09fbdc118597196a0b32,
           128'h3243f6a8885a308d313198a2e0370734);

    // Random keys and blocks against the reference model.
    for (int i = 0; i < 4; i++) begin
      rks  = m_expand(rand128());
      bus.round_keys = rks;
      pt_a = rand128();
      run_op("rnd_enc", 1'b0, pt_a, m_cipher(1'b0, pt_a, rks));
      pt_b = rand128();
      run_op("rnd_dec", 1'b1, pt_b, m_cipher(1'b1, pt_b, rks));
    end

    // Start while busy (edge k+5) and start on the completion edge are ignored.
    pt_a  = rand128();
    pt_b  = rand128();
    exp_a = m_cipher(1'b0, pt_a, rks);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 1'b0; bus.data_in = pt_a;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 1'b1; bus.data_in = pt_b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("sb:busy", {127'd0, bus.busy}, 128'd1);
    for (int i = 6; i <= 10; i++) begin
      if (i == 10) begin
        @(negedge clk);
        bus.start = 1'b1; bus.data_in = pt_b;
      end
      @(posedge clk); #1;
      if (i == 10) bus.start = 1'b0;
      chk("sb:done_edge", {127'd0, bus.done}, {127'd0, (i == 10)});
    end
    chk("sb:data", bus.data_out, exp_a);
    any_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      any_done = any_done | bus.done | bus.busy;
    end
    chk("sb:no_extra", {127'd0, any_done}, 128'd0);

    // Reset mid-operation aborts with no done.
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 1'b0; bus.data_in = pt_b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rmid:data_out", bus.data_out, 128'd0);
    chk("rmid:busy", {127'd0, bus.busy}, 128'd0);
    chk("rmid:done", {127'd0, bus.done}, 128'd0);
    chk("rmid:bcd",  {116'd0, bus.bcd_out}, 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    any_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      any_done = any_done | bus.done;
    end
    chk("rmid:no_done", {127'd0, any_done}, 128'd0);
    run_op("rmid_next", 1'b0, pt_b, m_cipher(1'b0, pt_b, rks));

    // BCD boundaries via decrypt of model-encrypted targets.
    lows[0] = 8'h00; lows[1] = 8'h09; lows[2] = 8'h63; lows[3] = 8'h64;
    for (int i = 0; i < 4; i++) begin
      tgt      = rand128();
      tgt[7:0] = lows[i];
      ct       = m_cipher(1'b0, tgt, rks);
      run_op("bcd_bound", 1'b1, ct, tgt);
    end

    // Back-to-back: start held high gives one done every 11 cycles.
    pt_a  = rand128();
    pt_b  = rand128();
    exp_a = m_cipher(1'b0, pt_a, rks);
    exp_b = m_cipher(1'b0, pt_b, rks);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 1'b0; bus.data_in = pt_a;
    @(posedge clk); #1;
    wait_done(lat);
    chk("b2b:lat1", 128'(lat), 128'd10);
    chk("b2b:data1", bus.data_out, exp_a);
    bus.data_in = pt_b;
    wait_done(lat);
    chk("b2b:lat2", 128'(lat), 128'd11);
    chk("b2b:data2", bus.data_out, exp_b);
    bus.start = 1'b0;
    repeat (12) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
